// File: rtl/mem_port_master_pkg.sv
// Shared definitions for the byte-RAM initiator: default widths, FSM state
// encoding and request-size codes.
package mem_port_master_pkg;

  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;

endpackage

// File: rtl/mem_port_master.sv
// Turns CPU byte/word load-store requests into one or two little-endian
// accesses on a single-port byte RAM and returns load data with a done pulse.
module mem_port_master
  import mem_port_master_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  req_we,
  input  logic                  req_word,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic                  busy,
  output logic                  done,
  output logic [2*DATA_W-1:0]   rdata,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W-1:0]     mem_datain,
  output logic                  mem_we,
  input  logic [DATA_W-1:0]     mem_dataout
);

  state_t                state;
  logic [ADDR_W-1:0]     addr_q;
  logic                  we_q;
  logic                  word_q;
  logic [2*DATA_W-1:0]   wdata_q;

  // mem_address/mem_datain are registered and only change on entry to an
  // access state, so they naturally hold their last value in IDLE and DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      word_q      <= SIZE_BYTE;
      wdata_q     <= '0;
      rdata       <= '0;
      mem_address <= '0;
      mem_datain  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            addr_q      <= req_addr;
            we_q        <= req_we;
            word_q      <= req_word;
            wdata_q     <= req_wdata;
            mem_address <= req_addr;
            mem_datain  <= req_wdata[DATA_W-1:0];
            state       <= ACC0;
          end
        end
        ACC0: begin
          if (!we_q) begin
            rdata[DATA_W-1:0] <= mem_dataout;
            if (word_q == SIZE_BYTE) rdata[2*DATA_W-1:DATA_W] <= '0;
          end
          if (word_q == SIZE_WORD) begin
            mem_address <= addr_q + ADDR_W'(1);
            mem_datain  <= wdata_q[2*DATA_W-1:DATA_W];
            state       <= ACC1;
          end else begin
            state <= DONE;
          end
        end
        ACC1: begin
          if (!we_q) rdata[2*DATA_W-1:DATA_W] <= mem_dataout;
          state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  // Gating with rst keeps the reset edge itself from committing a write.
  assign mem_we = ((state == ACC0) || (state == ACC1)) && we_q && !rst;

endmodule

// File: tb/tb_mem_port_master.sv
// Bench for mem_port_master: behavioural byte RAM, directed vector table,
// hand-written corner sequences and randomized traffic against a byte-array model.
module tb_mem_port_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        req_we = 1'b0;
  logic        req_word = 1'b0;
  logic [14:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        busy, done, mem_we;
  logic [15:0] rdata;
  logic [14:0] mem_address;
  logic [7:0]  mem_datain, mem_dataout;

  mem_port_master #(.ADDR_W(15), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_word(req_word),
    .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy), .done(done),
    .rdata(rdata), .mem_address(mem_address), .mem_datain(mem_datain),
    .mem_we(mem_we), .mem_dataout(mem_dataout)
  );

  always #5 clk = ~clk;

  // Single-port byte RAM with combinational read, plus a backdoor for preload.
  logic [7:0]  ram [0:32767];
  logic        tb_clr = 1'b0;
  logic        tb_wr = 1'b0;
  logic [14:0] tb_wa = '0;
  logic [7:0]  tb_wd = '0;
  always @(posedge clk) begin
    if (tb_clr) begin
      for (int i = 0; i < 32768; i++) ram[i] <= 8'h00;
    end else if (mem_we) begin
      ram[mem_address] <= mem_datain;
    end else if (tb_wr) begin
      ram[tb_wa] <= tb_wd;
    end
  end
  assign mem_dataout = ram[mem_address];

  // Reference model: flat byte memory plus the last load result.
  logic [7:0]  ref_mem [0:32767];
  logic [15:0] model_rdata = '0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_apply(input logic we, input logic word, input logic [14:0] a,
                             input logic [15:0] wd);
    logic [14:0] a1;
    a1 = a + 15'd1;
    if (we) begin
      ref_mem[a] = wd[7:0];
      if (word) ref_mem[a1] = wd[15:8];
    end else begin
      model_rdata = word ? {ref_mem[a1], ref_mem[a]} : {8'h00, ref_mem[a]};
    end
  endtask

  task automatic preload(input logic [14:0] a, input logic [7:0] d);
    tb_wr = 1'b1; tb_wa = a; tb_wd = d;
    @(posedge clk); #1;
    tb_wr = 1'b0;
    ref_mem[a] = d;
  endtask

  // Issues one request once the master is idle; lat counts edges from the
  // accepting edge to the one after which done is seen (-1 on timeout).
  task automatic do_req(input logic we, input logic word, input logic [14:0] a,
                        input logic [15:0] wd, output int lat, output int we_cyc,
                        output logic [14:0] we_addr);
    int guard;
    guard = 0;
    while (busy && guard < 10) begin
      @(posedge clk); #1;
      guard++;
    end
    req = 1'b1; req_we = we; req_word = word; req_addr = a; req_wdata = wd;
    lat = 0; we_cyc = 0; we_addr = '0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      lat++;
      if (k == 0) begin
        req = 1'b0;
        req_we = 1'($urandom); req_word = 1'($urandom);
        req_addr = 15'($urandom); req_wdata = 16'($urandom);
      end
      if (mem_we) begin
        if (we_cyc == 0) we_addr = mem_address;
        we_cyc++;
      end
      if (done) break;
    end
    if (!done) lat = -1;
  endtask

  typedef struct {
    logic        we;
    logic        word;
    logic [14:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    int          exp_lat;
    int          exp_we_cyc;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int lat, we_cyc, dcount;
    logic [14:0] we_addr;

    vecs[0] = '{1'b0, 1'b1, 15'h0000, 16'h0000, 16'h0104, 3, 0};
    vecs[1] = '{1'b1, 1'b0, 15'h0010, 16'h55AB, 16'h0104, 2, 1};
    vecs[2] = '{1'b0, 1'b0, 15'h0010, 16'h0000, 16'h00AB, 2, 0};
    vecs[3] = '{1'b1, 1'b1, 15'h7FFF, 16'hBEEF, 16'h00AB, 3, 2};
    vecs[4] = '{1'b0, 1'b1, 15'h7FFF, 16'h0000, 16'hBEEF, 3, 0};
    vecs[5] = '{1'b0, 1'b0, 15'h0000, 16'h0000, 16'h00BE, 2, 0};
    vecs[6] = '{1'b0, 1'b1, 15'h0000, 16'h0000, 16'h01BE, 3, 0};
    vecs[7] = '{1'b0, 1'b0, 15'h0003, 16'h0000, 16'h0009, 2, 0};

    for (int i = 0; i < 32768; i++) ref_mem[i] = 8'h00;

    // Reset, clear RAM and preload while the master is held in reset.
    @(posedge clk); #1;
    tb_clr = 1'b1;
    @(posedge clk); #1;
    tb_clr = 1'b0;
    preload(15'h0000, 8'h04);
    preload(15'h0001, 8'h01);
    preload(15'h0003, 8'h09);
    preload(15'h0021, 8'h5A);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_mem_we", 32'(mem_we), 32'd0);
    chk("reset_rdata", 32'(rdata), 32'd0);
    chk("reset_mem_address", 32'(mem_address), 32'd0);
    chk("reset_mem_datain", 32'(mem_datain), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table; the last entry runs straight after a word-load done.
    for (int i = 0; i < 8; i++) begin
      do_req(vecs[i].we, vecs[i].word, vecs[i].addr, vecs[i].wdata, lat, we_cyc, we_addr);
      model_apply(vecs[i].we, vecs[i].word, vecs[i].addr, vecs[i].wdata);
      $display("vec %0d we=%0d word=%0d addr=%h wdata=%h rdata=%h lat=%0d we_cycles=%0d",
               i, vecs[i].we, vecs[i].word, vecs[i].addr, vecs[i].wdata, rdata, lat, we_cyc);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("vec%0d_rdata", i), 32'(rdata), 32'(vecs[i].exp_rdata));
      chk($sformatf("vec%0d_we_cycles", i), 32'(we_cyc), 32'(vecs[i].exp_we_cyc));
      if (vecs[i].exp_we_cyc > 0)
        chk($sformatf("vec%0d_we_addr", i), 32'(we_addr), 32'(vecs[i].addr));
      if (i == 0) begin
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_after_done", 32'(busy), 32'd0);
      end
    end
    chk("wrap_ram_7fff", 32'(ram[15'h7FFF]), 32'h00EF);
    chk("wrap_ram_0000", 32'(ram[15'h0000]), 32'h00BE);
    chk("byte_store_ram_0011", 32'(ram[15'h0011]), 32'h0000);

    // req during ACC0 of a word store must be ignored.
    while (busy) begin @(posedge clk); #1; end
    req = 1'b1; req_we = 1'b1; req_word = 1'b1; req_addr = 15'h0040; req_wdata = 16'h5566;
    @(posedge clk); #1;
    req = 1'b1; req_we = 1'b1; req_word = 1'b0; req_addr = 15'h0050; req_wdata = 16'h0077;
    @(posedge clk); #1;
    req = 1'b0;
    dcount = 0;
    for (int k = 0; k < 6; k++) begin
      dcount += 32'(done);
      @(posedge clk); #1;
    end
    model_apply(1'b1, 1'b1, 15'h0040, 16'h5566);
    $display("txn ignored-req: word store 5566@0040 with extra req, dones=%0d", dcount);
    chk("ignored_req_dones", 32'(dcount), 32'd1);
    chk("ignored_req_ram_0040", 32'(ram[15'h0040]), 32'h0066);
    chk("ignored_req_ram_0041", 32'(ram[15'h0041]), 32'h0055);
    chk("ignored_req_ram_0050", 32'(ram[15'h0050]), 32'h0000);
    chk("ignored_req_busy", 32'(busy), 32'd0);

    // Reset while in ACC1 of a word store.
    req = 1'b1; req_we = 1'b1; req_word = 1'b1; req_addr = 15'h0020; req_wdata = 16'h1234;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    dcount = 0;
    @(posedge clk); #1;
    dcount += 32'(done);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      dcount += 32'(done);
    end
    ref_mem[15'h0020] = 8'h34;
    model_rdata = '0;
    $display("txn rst-mid: word store 1234@0020 aborted in second access, dones=%0d", dcount);
    chk("rst_mid_dones", 32'(dcount), 32'd0);
    chk("rst_mid_ram_0020", 32'(ram[15'h0020]), 32'h0034);
    chk("rst_mid_ram_0021", 32'(ram[15'h0021]), 32'h005A);
    chk("rst_mid_rdata", 32'(rdata), 32'd0);

    // Simultaneous rst and req: request dropped.
    rst = 1'b1; req = 1'b1; req_we = 1'b1; req_word = 1'b0; req_addr = 15'h0060; req_wdata = 16'h0099;
    @(posedge clk); #1;
    rst = 1'b0; req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    $display("txn rst+req: byte store 99@0060 with reset");
    chk("rst_req_busy", 32'(busy), 32'd0);
    chk("rst_req_ram_0060", 32'(ram[15'h0060]), 32'h0000);

    // Randomized traffic against the model.
    for (int n = 0; n < 150; n++) begin
      logic        r_we, r_word;
      logic [14:0] r_addr, r_a1;
      logic [15:0] r_wd;
      int          sel;
      r_we = 1'($urandom);
      r_word = 1'($urandom);
      sel = int'($urandom_range(0, 3));
      if (sel == 0)      r_addr = 15'($urandom_range(0, 63));
      else if (sel == 1) r_addr = 15'h7FF0 + 15'($urandom_range(0, 15));
      else               r_addr = 15'($urandom);
      r_wd = 16'($urandom);
      r_a1 = r_addr + 15'd1;
      do_req(r_we, r_word, r_addr, r_wd, lat, we_cyc, we_addr);
      model_apply(r_we, r_word, r_addr, r_wd);
      $display("rnd %0d we=%0d word=%0d addr=%h wdata=%h rdata=%h lat=%0d",
               n, r_we, r_word, r_addr, r_wd, rdata, lat);
      chk("rnd_lat", 32'(lat), r_word ? 32'd3 : 32'd2);
      chk("rnd_we_cycles", 32'(we_cyc), r_we ? (r_word ? 32'd2 : 32'd1) : 32'd0);
      chk("rnd_rdata", 32'(rdata), 32'(model_rdata));
      if (r_we) begin
        chk("rnd_ram_lo", 32'(ram[r_addr]), 32'(ref_mem[r_addr]));
        chk("rnd_ram_hi", 32'(ram[r_a1]), 32'(ref_mem[r_a1]));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
